// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard controller slice.
//   - PS/2 set-2 prefix bytes
//   - parser state encoding
//   - status-port bit positions
//   - helper that flags controller/handshake bytes ignored between keys
package kbd_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, PUSH2} parse_e;

  // status port layout: {ovf, 0, sys, 0000, not_empty}
  localparam int ST_OVF = 7;
  localparam int ST_SYS = 5;
  localparam int ST_NE  = 0;

  // ACK, BAT-ok, echo, resend, and the two error codes
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/kbd_set2_to_set1.sv
// Scan-code set 2 -> set 1 lookup, purely combinational.
//   code2 : set-2 byte (without E0/F0 prefixes)
//   code1 : set-1 make code, 8'h00 when the byte has no mapping
// Extended keys share the base table (E0 prefix is carried separately),
// plus the three GUI/menu keys that only exist behind E0.
module kbd_set2_to_set1 (
  input  logic [7:0] code2,
  output logic [7:0] code1
);

  always_comb begin
    code1 = 8'h00;
    case (code2)
      8'h01: code1 = 8'h43;  8'h03: code1 = 8'h3F;  8'h04: code1 = 8'h3D;  8'h05: code1 = 8'h3B;
      8'h06: code1 = 8'h3C;  8'h07: code1 = 8'h58;  8'h09: code1 = 8'h44;  8'h0A: code1 = 8'h42;
      8'h0B: code1 = 8'h40;  8'h0C: code1 = 8'h3E;  8'h0D: code1 = 8'h0F;  8'h0E: code1 = 8'h29;
      8'h11: code1 = 8'h38;  8'h12: code1 = 8'h2A;  8'h14: code1 = 8'h1D;  8'h15: code1 = 8'h10;
      8'h16: code1 = 8'h02;  8'h1A: code1 = 8'h2C;  8'h1B: code1 = 8'h1F;  8'h1C: code1 = 8'h1E;
      8'h1D: code1 = 8'h11;  8'h1E: code1 = 8'h03;  8'h1F: code1 = 8'h5B;  8'h21: code1 = 8'h2E;
      8'h22: code1 = 8'h2D;  8'h23: code1 = 8'h20;  8'h24: code1 = 8'h12;  8'h25: code1 = 8'h05;
      8'h26: code1 = 8'h04;  8'h27: code1 = 8'h5C;  8'h29: code1 = 8'h39;  8'h2A: code1 = 8'h2F;
      8'h2B: code1 = 8'h21;  8'h2C: code1 = 8'h14;  8'h2D: code1 = 8'h13;  8'h2E: code1 = 8'h06;
      8'h2F: code1 = 8'h5D;  8'h31: code1 = 8'h31;  8'h32: code1 = 8'h30;  8'h33: code1 = 8'h23;
      8'h34: code1 = 8'h22;  8'h35: code1 = 8'h15;  8'h36: code1 = 8'h07;  8'h3A: code1 = 8'h32;
      8'h3B: code1 = 8'h24;  8'h3C: code1 = 8'h16;  8'h3D: code1 = 8'h08;  8'h3E: code1 = 8'h09;
      8'h41: code1 = 8'h33;  8'h42: code1 = 8'h25;  8'h43: code1 = 8'h17;  8'h44: code1 = 8'h18;
      8'h45: code1 = 8'h0B;  8'h46: code1 = 8'h0A;  8'h49: code1 = 8'h34;  8'h4A: code1 = 8'h35;
      8'h4B: code1 = 8'h26;  8'h4C: code1 = 8'h27;  8'h4D: code1 = 8'h19;  8'h4E: code1 = 8'h0C;
      8'h52: code1 = 8'h28;  8'h54: code1 = 8'h1A;  8'h55: code1 = 8'h0D;  8'h58: code1 = 8'h3A;
      8'h59: code1 = 8'h36;  8'h5A: code1 = 8'h1C;  8'h5B: code1 = 8'h1B;  8'h5D: code1 = 8'h2B;
      8'h66: code1 = 8'h0E;  8'h69: code1 = 8'h4F;  8'h6B: code1 = 8'h4B;  8'h6C: code1 = 8'h47;
      8'h70: code1 = 8'h52;  8'h71: code1 = 8'h53;  8'h72: code1 = 8'h50;  8'h73: code1 = 8'h4C;
      8'h74: code1 = 8'h4D;  8'h75: code1 = 8'h48;  8'h76: code1 = 8'h01;  8'h77: code1 = 8'h45;
      8'h78: code1 = 8'h57;  8'h79: code1 = 8'h4E;  8'h7A: code1 = 8'h51;  8'h7B: code1 = 8'h4A;
      8'h7C: code1 = 8'h37;  8'h7D: code1 = 8'h49;  8'h7E: code1 = 8'h46;  8'h83: code1 = 8'h41;
      default: code1 = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_ctrl_fifo.sv
// PS/2 keyboard controller: set-2 parser, set-1 translation, DEPTH-entry FIFO.
//   iClk/iRstN              clock, async active-low reset
//   iAddr/iRd/iWr/iData     CPU port bus (data, control = +1, status = +4)
//   oSel/oData              read response, one cycle after iRd to a decoded port
//   oIrq                    level IRQ1, high while the FIFO holds data
//   oSpkGate/oSpkEnable     control port bits 0/1
//   iRxValid/iRxData        byte strobe from the ps2_device receiver
// Build option: KBD_TYPEMATIC_FILTER_EN drops repeated makes of a held key.
module kbd_ctrl_fifo
  import kbd_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [11:0] PORT_BASE = 12'h060
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [19:0] iAddr,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [7:0]  iData,
  output logic        oSel,
  output logic [7:0]  oData,
  output logic        oIrq,
  output logic        oSpkGate,
  output logic        oSpkEnable,
  input  logic        iRxValid,
  input  logic [7:0]  iRxData
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_M2 = CW'(DEPTH - 2);

  // port decode (only the low 12 address bits take part)
  logic [11:0] addr;
  logic        unused_addr_hi;
  logic        sel_data, sel_ctrl, sel_stat, flush;
  assign addr           = iAddr[11:0];
  assign unused_addr_hi = ^iAddr[19:12];
  assign sel_data = (addr == PORT_BASE);
  assign sel_ctrl = (addr == PORT_BASE + 12'd1);
  assign sel_stat = (addr == PORT_BASE + 12'd4);
  assign flush    = iWr & sel_ctrl & iData[7];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          ovf, push, pop, ovf_set;
  logic [7:0]    push_data, ctrl, last_data, status;

  parse_e     state, state_nxt;
  logic       p2_phase, p2_phase_nxt;     // PUSH2: 0 = E0 slot, 1 = code slot
  logic       pend_vld, pend_vld_nxt;     // single-byte emit waiting to push
  logic [7:0] emit_code, emit_code_nxt;
  logic       hold_vld, hold_vld_nxt;
  logic [7:0] hold, hold_nxt;
  logic       in_vld, emit, emit_ext, emit_brk, emit_ok, filt_hit;
  logic [7:0] in_byte, xlat;

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic       last_vld;
  logic [7:0] last_key;                   // {ext, set-1 make[6:0]}
`endif

  // bytes arriving while PUSH2 is busy wait in the holding register
  always_comb begin
    in_vld  = (state != PUSH2) && (hold_vld || iRxValid);
    in_byte = hold_vld ? hold : iRxData;
  end

  always_comb begin
    hold_vld_nxt = hold_vld;
    hold_nxt     = hold;
    if (state == PUSH2) begin
      if (iRxValid) begin hold_vld_nxt = 1'b1; hold_nxt = iRxData; end
    end else if (hold_vld) begin
      hold_vld_nxt = iRxValid;
      if (iRxValid) hold_nxt = iRxData;
    end
    if (flush) hold_vld_nxt = 1'b0;
  end

  kbd_set2_to_set1 u_xlat (.code2(in_byte), .code1(xlat));

  // parser next state and emit decision
  always_comb begin
    state_nxt    = state;
    p2_phase_nxt = 1'b0;
    emit = 1'b0; emit_ext = 1'b0; emit_brk = 1'b0;
    unique case (state)
      IDLE: if (in_vld) begin
        if (in_byte == PS2_BREAK)    state_nxt = BRK;
        else if (in_byte == PS2_EXT) state_nxt = EXT;
        else                         emit = !is_ignored(in_byte);
      end
      BRK: if (in_vld) begin
        state_nxt = IDLE; emit = (in_byte != PS2_EXT); emit_brk = 1'b1;
      end
      EXT: if (in_vld) begin
        if (in_byte == PS2_BREAK) state_nxt = EXT_BRK;
        else begin state_nxt = IDLE; emit = 1'b1; emit_ext = 1'b1; end
      end
      EXT_BRK: if (in_vld) begin
        state_nxt = IDLE; emit = (in_byte != PS2_EXT); emit_ext = 1'b1; emit_brk = 1'b1;
      end
      PUSH2: begin
        // slot 0 proceeds only with room for both bytes, else the pair is dropped
        if (!p2_phase && count <= FULL_M2) p2_phase_nxt = 1'b1;
        else                               state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef KBD_TYPEMATIC_FILTER_EN
    filt_hit = !emit_brk && last_vld && (last_key == {emit_ext, xlat[6:0]});
`else
    filt_hit = 1'b0;
`endif
    emit_ok       = emit && (xlat != 8'h00) && !filt_hit;
    emit_code_nxt = emit_brk ? (xlat | 8'h80) : xlat;
    pend_vld_nxt  = emit_ok && !emit_ext && !flush;
    if (emit_ok && emit_ext) state_nxt = PUSH2;
    if (flush) begin state_nxt = IDLE; p2_phase_nxt = 1'b0; end
  end

  // FIFO push/pop
  always_comb begin
    push = 1'b0; ovf_set = 1'b0; push_data = emit_code;
    if (state == PUSH2) begin
      if (p2_phase)                push = 1'b1;
      else if (count <= FULL_M2) begin push = 1'b1; push_data = PS2_EXT; end
      else                         ovf_set = 1'b1;
    end else if (pend_vld) begin
      if (count == FULL) ovf_set = 1'b1;
      else               push = 1'b1;
    end
    if (flush) begin push = 1'b0; ovf_set = 1'b0; end
    pop       = iRd && sel_data && (count != '0) && !flush;
    count_nxt = flush ? '0 : count + CW'(push) - CW'(pop);
  end

  always_comb begin
    status         = 8'h00;
    status[ST_OVF] = ovf;
    status[ST_SYS] = 1'b1;
    status[ST_NE]  = (count != '0);
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state    <= IDLE;
      p2_phase <= 1'b0;
    end else begin
      state    <= state_nxt;
      p2_phase <= p2_phase_nxt;
    end
  end

  always_ff @(posedge iClk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pend_vld <= 1'b0;  emit_code <= 8'h00;
      hold_vld <= 1'b0;  hold      <= 8'h00;
      wr_ptr   <= '0;    rd_ptr    <= '0;    count <= '0;
      ovf      <= 1'b0;  ctrl      <= 8'h00;
      oSel     <= 1'b0;  oData     <= 8'h00; last_data <= 8'h00;
      oIrq     <= 1'b0;
    end else begin
      pend_vld <= pend_vld_nxt;
      if (emit_ok) emit_code <= emit_code_nxt;
      hold_vld <= hold_vld_nxt;
      hold     <= hold_nxt;
      count    <= count_nxt;
      oIrq     <= (count_nxt != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // a fresh overflow outranks the clear from a status read
      if (ovf_set)              ovf <= 1'b1;
      else if (iRd && sel_stat) ovf <= 1'b0;
      if (iWr && sel_ctrl) ctrl <= iData;
      oSel <= iRd && (sel_data || sel_ctrl || sel_stat);
      if (iRd && sel_data) begin
        if (count != '0) begin
          oData     <= mem[rd_ptr];
          last_data <= mem[rd_ptr];
        end else begin
          oData <= last_data;
        end
      end else if (iRd && sel_ctrl) begin
        oData <= ctrl;
      end else if (iRd && sel_stat) begin
        oData <= status;
      end
    end
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      last_vld <= 1'b0;
      last_key <= 8'h00;
    end else if (flush) begin
      last_vld <= 1'b0;
    end else if (emit_ok && !emit_brk) begin
      last_vld <= 1'b1;
      last_key <= {emit_ext, xlat[6:0]};
    end else if (emit && emit_brk && last_key == {emit_ext, xlat[6:0]}) begin
      last_vld <= 1'b0;
    end
  end
`endif

  assign oSpkGate   = ctrl[0];
  assign oSpkEnable = ctrl[1];

endmodule

// File: tb/tb_kbd_ctrl_fifo.sv
module tb_kbd_ctrl_fifo;

  logic        iClk = 1'b0, iRstN = 1'b0;
  logic [19:0] iAddr = '0;
  logic        iRd = 1'b0, iWr = 1'b0, iRxValid = 1'b0;
  logic [7:0]  iData = '0, iRxData = '0;
  logic        oSel, oIrq, oSpkGate, oSpkEnable;
  logic [7:0]  oData;

  kbd_ctrl_fifo #(.DEPTH(8), .PORT_BASE(12'h060)) dut (
    .iClk(iClk), .iRstN(iRstN), .iAddr(iAddr), .iRd(iRd), .iWr(iWr), .iData(iData),
    .oSel(oSel), .oData(oData), .oIrq(oIrq), .oSpkGate(oSpkGate), .oSpkEnable(oSpkEnable),
    .iRxValid(iRxValid), .iRxData(iRxData)
  );

  always #5 iClk = ~iClk;

  int total = 0, bad = 0;
  logic [7:0] exp_q[$];

  // set-2 makes of keys 1..9 and their set-1 codes
  logic [7:0] s2[9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] s1[9] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // monitor: every read response is matched against the scoreboard
  always @(negedge iClk) begin : mon
    logic [7:0] e;
    if (iRstN && oSel) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_sel: got %02h expected no response", oData);
      end else begin
        e = exp_q.pop_front();
        check("port_read", oData, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic rx(input logic [7:0] b);
    @(negedge iClk); iRxValid = 1'b1; iRxData = b;
    @(negedge iClk); iRxValid = 1'b0;
  endtask

  task automatic rd(input logic [19:0] a, input logic [7:0] e);
    @(negedge iClk); iRd = 1'b1; iAddr = a; exp_q.push_back(e);
    @(negedge iClk); iRd = 1'b0;
  endtask

  task automatic wr(input logic [19:0] a, input logic [7:0] d);
    @(negedge iClk); iWr = 1'b1; iAddr = a; iData = d;
    @(negedge iClk); iWr = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // reset values
    tick(2);
    check("rst_sel",  {7'd0, oSel}, 8'h00);
    check("rst_data", oData, 8'h00);
    check("rst_irq",  {7'd0, oIrq}, 8'h00);
    check("rst_spk",  {6'd0, oSpkEnable, oSpkGate}, 8'h00);
    @(negedge iClk); iRstN = 1'b1;
    rd(20'h00064, 8'h20);

    // single make, IRQ timing
    rx(8'h1C);
    check("irq_n1", {7'd0, oIrq}, 8'h00);
    tick(1);
    check("irq_n2", {7'd0, oIrq}, 8'h01);
    rd(20'h00060, 8'h1E);
    check("irq_after_pop", {7'd0, oIrq}, 8'h00);

    // break, then empty read repeats last value
    rx(8'hF0); rx(8'h1C); tick(2);
    rd(20'h00060, 8'h9E);
    rd(20'h00060, 8'h9E);
    rd(20'h00064, 8'h20);

    // extended make / break, and a byte landing during PUSH2
    rx(8'hE0); rx(8'h75); tick(2);
    rd(20'h00060, 8'hE0); rd(20'h00060, 8'h48);
    rx(8'hE0); rx(8'hF0); rx(8'h75); tick(2);
    rd(20'h00060, 8'hE0); rd(20'h00060, 8'hC8);
    rx(8'hE0); rx(8'h75); rx(8'h1C); tick(2);
    rd(20'h00060, 8'hE0); rd(20'h00060, 8'h48); rd(20'h00060, 8'h1E);

    // ignored bytes, undecoded reads, writes to data/status ports
    rx(8'hFA); rx(8'hAA); tick(2);
    @(negedge iClk); iRd = 1'b1; iAddr = 20'h00062;
    @(negedge iClk); iRd = 1'b0;
    check("undecoded_sel", {7'd0, oSel}, 8'h00);
    wr(20'h00060, 8'h55); wr(20'h00064, 8'h55);
    rd(20'hF0064, 8'h20);

    // 9 makes into 8 entries
    for (int i = 0; i < 9; i++) rx(s2[i]);
    tick(2);
    rd(20'h00064, 8'hA1);
    rd(20'h00064, 8'h21);
    for (int i = 0; i < 8; i++) rd(20'h00060, s1[i]);
    rd(20'h00064, 8'h20);

    // extended pair with one slot free: both dropped
    for (int i = 0; i < 7; i++) rx(s2[i]);
    rx(8'hE0); rx(8'h75); tick(3);
    rd(20'h00064, 8'hA1);
    for (int i = 0; i < 7; i++) rd(20'h00060, s1[i]);
    rd(20'h00064, 8'h20);

    // extended pair with two slots free: both accepted
    for (int i = 0; i < 6; i++) rx(s2[i]);
    rx(8'hE0); rx(8'h75); tick(3);
    rd(20'h00064, 8'h21);
    for (int i = 0; i < 6; i++) rd(20'h00060, s1[i]);
    rd(20'h00060, 8'hE0); rd(20'h00060, 8'h48);
    rd(20'h00064, 8'h20);

    // push and pop on the same edge with three queued
    for (int i = 0; i < 3; i++) rx(s2[i]);
    tick(2);
    @(negedge iClk); iRxValid = 1'b1; iRxData = 8'h2E;
    @(negedge iClk); iRxValid = 1'b0; iRd = 1'b1; iAddr = 20'h00060; exp_q.push_back(8'h02);
    @(negedge iClk); iRd = 1'b0;
    rd(20'h00060, 8'h03); rd(20'h00060, 8'h04); rd(20'h00060, 8'h06);
    rd(20'h00064, 8'h20);

    // flush via control port, parser left mid-break
    rx(8'h16); rx(8'hF0); tick(2);
    wr(20'h00061, 8'h83);
    check("flush_irq", {7'd0, oIrq}, 8'h00);
    check("flush_spk", {6'd0, oSpkEnable, oSpkGate}, 8'h03);
    rd(20'h00061, 8'h83);
    rd(20'h00064, 8'h20);
    rx(8'h1C); tick(2);
    rd(20'h00060, 8'h1E);
    rd(20'h00060, 8'h1E);

    // typematic repeats
    rx(8'h1C); rx(8'h1C); rx(8'hF0); rx(8'h1C); rx(8'h1C); tick(2);
`ifdef KBD_TYPEMATIC_FILTER_EN
    rd(20'h00060, 8'h1E); rd(20'h00060, 8'h9E); rd(20'h00060, 8'h1E);
`else
    rd(20'h00060, 8'h1E); rd(20'h00060, 8'h1E); rd(20'h00060, 8'h9E);
    rd(20'h00060, 8'h1E); rd(20'h00060, 8'h1E);
`endif
    rd(20'h00064, 8'h20);

    // async reset in the middle of PUSH2
    wr(20'h00061, 8'h03);
    rx(8'h1C); tick(2);
    rx(8'hE0); rx(8'h75);
    #1 iRstN = 1'b0;
    #1;
    check("mid_rst_irq",  {7'd0, oIrq}, 8'h00);
    check("mid_rst_spk",  {6'd0, oSpkEnable, oSpkGate}, 8'h00);
    check("mid_rst_sel",  {7'd0, oSel}, 8'h00);
    check("mid_rst_data", oData, 8'h00);
    @(negedge iClk); iRstN = 1'b1;
    tick(3);
    rd(20'h00064, 8'h20);
    check("post_rst_irq", {7'd0, oIrq}, 8'h00);

    tick(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_responses: got %0d outstanding expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
